// File: rtl/ptp_master_msg.sv
// PTP two-step master message engine: local clock, Sync/Follow_Up
// generation and Delay_Req -> Delay_Resp answering over UDP payload words.
module ptp_master_msg #(
    parameter logic [47:0] BOARD_MAC     = 48'hDC_FE_07_19_68_33,
    parameter int unsigned CLK_PERIOD_NS = 8,
    parameter int unsigned SYNC_INTERVAL = 125_000_000
) (
    input  logic        eth_clk_125m,
    input  logic        rst,
    input  logic        ptp_en,
    input  logic        time_set,
    input  logic [47:0] set_sec,
    input  logic [31:0] set_ns,
    input  logic        rx_valid,
    input  logic [15:0] rx_data_cnt,
    input  logic [31:0] rx_data,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [31:0] tx_data,
    input  logic        tx_done,
    output logic [47:0] tsecond,
    output logic [31:0] tnano,
    output logic [15:0] sync_seqid,
    output logic [15:0] req_drop_cnt
);

    localparam logic [31:0] NS_STEP = 32'(CLK_PERIOD_NS);
    localparam logic [31:0] NS_LAST = 32'(1_000_000_000 - CLK_PERIOD_NS);
    localparam int          TW      = $clog2(SYNC_INTERVAL);
    localparam logic [TW-1:0] TMAX  = TW'(SYNC_INTERVAL - 1);
    localparam logic [63:0] CLK_ID  = {BOARD_MAC[47:24], 8'hFF, 8'hFE, BOARD_MAC[23:0]};

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_WAIT} state_t;
    typedef enum logic [1:0] {M_SYNC, M_FUP, M_RESP} msg_t;

    state_t        state_q, state_d;
    msg_t          msg_q, msg_d;
    logic          sync_go, resp_go;
    logic [47:0]   sec_q;
    logic [31:0]   ns_q;
    logic [TW-1:0] tmr_q;
    logic          sync_due_q;
    logic [3:0]    idx_q;
    logic [3:0]    last_idx;
    logic [31:0]   tx_data_q, word_d;
    logic [15:0]   byte_num_q;
    logic [15:0]   seqid_q, seq_nxt_q;
    logic [79:0]   t1_q;
    logic          armed_q, commit;
    logic [79:0]   cap_t4_q, pend_t4_q, out_t4_q;
    logic [63:0]   cap_id_q, pend_id_q, out_id_q;
    logic [31:0]   cap_ps_q, pend_ps_q, out_ps_q;
    logic          pend_q;
    logic [15:0]   drop_q;
    logic [79:0]   ts;
    logic [15:0]   seq;
    logic [7:0]    ctl, li;

    assign tx_start_en  = (state_q == S_START);
    assign tx_byte_num  = byte_num_q;
    assign tx_data      = tx_data_q;
    assign tsecond      = sec_q;
    assign tnano        = ns_q;
    assign sync_seqid   = seqid_q;
    assign req_drop_cnt = drop_q;
    assign last_idx     = (msg_q == M_RESP) ? 4'd13 : 4'd10;
    assign commit       = rx_valid && (rx_data_cnt == 16'd11) && armed_q;

    // Master time-of-day clock; a load request overrides counting
    always_ff @(posedge eth_clk_125m or posedge rst) begin
        if (rst) begin
            sec_q <= '0;
            ns_q  <= '0;
        end else if (time_set) begin
            sec_q <= set_sec;
            ns_q  <= set_ns;
        end else if (ns_q == NS_LAST) begin
            sec_q <= sec_q + 48'd1;
            ns_q  <= '0;
        end else begin
            ns_q <= ns_q + NS_STEP;
        end
    end

    // Free-running Sync interval timer and non-accumulating Sync request
    always_ff @(posedge eth_clk_125m or posedge rst) begin
        if (rst) begin
            tmr_q      <= '0;
            sync_due_q <= 1'b0;
        end else begin
            tmr_q <= (tmr_q == TMAX) ? '0 : tmr_q + TW'(1);
            if (tmr_q == TMAX && ptp_en)
                sync_due_q <= 1'b1;
            else if (sync_go)
                sync_due_q <= 1'b0;
        end
    end

    // Delay_Req field capture into a shadow set while the frame is armed
    always_ff @(posedge eth_clk_125m or posedge rst) begin
        if (rst) begin
            armed_q  <= 1'b0;
            cap_t4_q <= '0;
            cap_id_q <= '0;
            cap_ps_q <= '0;
        end else if (rx_data_cnt == 16'd0) begin
            armed_q <= 1'b0;
        end else if (rx_valid) begin
            case (rx_data_cnt)
                16'd1: begin
                    armed_q <= (rx_data[27:24] == 4'h1) && (rx_data[19:16] == 4'h2);
                    cap_t4_q <= {sec_q, ns_q};
                end
                16'd6:  if (armed_q) cap_id_q[63:32] <= rx_data;
                16'd7:  if (armed_q) cap_id_q[31:0]  <= rx_data;
                16'd8:  if (armed_q) cap_ps_q        <= rx_data;
                16'd11: armed_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Pending response slot; a response being started frees it the same cycle
    always_ff @(posedge eth_clk_125m or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_t4_q <= '0;
            pend_id_q <= '0;
            pend_ps_q <= '0;
            out_t4_q  <= '0;
            out_id_q  <= '0;
            out_ps_q  <= '0;
            drop_q    <= '0;
        end else begin
            if (resp_go) begin
                out_t4_q <= pend_t4_q;
                out_id_q <= pend_id_q;
                out_ps_q <= pend_ps_q;
            end
            if (commit && (!pend_q || resp_go)) begin
                pend_q    <= 1'b1;
                pend_t4_q <= cap_t4_q;
                pend_id_q <= cap_id_q;
                pend_ps_q <= cap_ps_q;
            end else if (resp_go) begin
                pend_q <= 1'b0;
            end
            if (commit && pend_q && !resp_go)
                drop_q <= drop_q + 16'd1;
        end
    end

    // Transmit sequencer next-state: Sync beats Resp, Follow_Up chained to Sync
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        sync_go = 1'b0;
        resp_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sync_due_q) begin
                    state_d = S_START;
                    msg_d   = M_SYNC;
                    sync_go = 1'b1;
                end else if (pend_q) begin
                    state_d = S_START;
                    msg_d   = M_RESP;
                    resp_go = 1'b1;
                end
            end
            S_START: state_d = S_SEND;
            S_SEND: begin
                if (tx_req && idx_q == last_idx)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (msg_q == M_SYNC) begin
                        state_d = S_START;
                        msg_d   = M_FUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payload word selected by the current message type and word index
    always_comb begin
        ts     = '0;
        ctl    = 8'h00;
        li     = 8'h00;
        seq    = seqid_q;
        word_d = '0;
        if (msg_q == M_FUP) begin
            ts  = t1_q;
            ctl = 8'h02;
        end else if (msg_q == M_RESP) begin
            ts  = out_t4_q;
            ctl = 8'h03;
            li  = 8'h7F;
            seq = out_ps_q[15:0];
        end
        case (idx_q)
            4'd0: begin
                if (msg_q == M_RESP)     word_d = 32'h0902_0036;
                else if (msg_q == M_FUP) word_d = 32'h0802_002C;
                else                     word_d = 32'h0002_002C;
            end
            4'd1:  word_d = (msg_q == M_SYNC) ? 32'h0000_0200 : 32'h0;
            4'd5:  word_d = CLK_ID[63:32];
            4'd6:  word_d = CLK_ID[31:0];
            4'd7:  word_d = {16'h0001, seq};
            4'd8:  word_d = {ctl, li, ts[79:64]};
            4'd9:  word_d = ts[63:32];
            4'd10: word_d = ts[31:0];
            4'd11: word_d = out_id_q[63:32];
            4'd12: word_d = out_id_q[31:0];
            4'd13: word_d = {out_ps_q[31:16], 16'h0000};
            default: word_d = '0;
        endcase
    end

    // Sequencer registers, word output, Sync sequence numbering and t1 capture
    always_ff @(posedge eth_clk_125m or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            msg_q      <= M_SYNC;
            idx_q      <= '0;
            tx_data_q  <= '0;
            byte_num_q <= '0;
            seqid_q    <= '0;
            seq_nxt_q  <= '0;
            t1_q       <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            if (state_d == S_START) begin
                idx_q      <= '0;
                byte_num_q <= (msg_d == M_RESP) ? 16'd54 : 16'd44;
            end
            if (sync_go) begin
                seqid_q   <= seq_nxt_q;
                seq_nxt_q <= seq_nxt_q + 16'd1;
            end
            if (state_q == S_SEND && tx_req) begin
                tx_data_q <= word_d;
                idx_q     <= idx_q + 4'd1;
                if (idx_q == 4'd0 && msg_q == M_SYNC)
                    t1_q <= {sec_q, ns_q};
            end
        end
    end

endmodule
